// File: rtl/iq_dispatcher_if.sv
// ---------------------------------------------------------------------------
// iq_dispatcher_if
//   Bundles the instruction-queue read port, the front-end hold, and the three
//   execution-lane valid/ready handshakes of the dispatcher.
//
//   Queue side : q_re, q_empty, q_needs_reset, q_reset, q_{dma,math,cache}_instr
//                (queue words carry their lane-valid bit in the MSB)
//   Front end  : fe_hold
//   Lanes      : {dma,math,cache}_{valid,ready,instr} (valid bit stripped)
//
//   master : dispatcher side
//   slave  : environment side (queue, front end, execution lanes)
// ---------------------------------------------------------------------------
interface iq_dispatcher_if #(
  parameter int DMA_W   = 45,
  parameter int MATH_W  = 10,
  parameter int CACHE_W = 46
);
  logic               q_re;
  logic               q_empty;
  logic               q_needs_reset;
  logic               q_reset;
  logic [DMA_W-1:0]   q_dma_instr;
  logic [MATH_W-1:0]  q_math_instr;
  logic [CACHE_W-1:0] q_cache_instr;
  logic               fe_hold;

  logic               dma_valid;
  logic               dma_ready;
  logic [DMA_W-2:0]   dma_instr;
  logic               math_valid;
  logic               math_ready;
  logic [MATH_W-2:0]  math_instr;
  logic               cache_valid;
  logic               cache_ready;
  logic [CACHE_W-2:0] cache_instr;

  modport master (
    output q_re, q_reset, fe_hold,
    output dma_valid, dma_instr, math_valid, math_instr, cache_valid, cache_instr,
    input  q_empty, q_needs_reset, q_dma_instr, q_math_instr, q_cache_instr,
    input  dma_ready, math_ready, cache_ready
  );

  modport slave (
    input  q_re, q_reset, fe_hold,
    input  dma_valid, dma_instr, math_valid, math_instr, cache_valid, cache_instr,
    output q_empty, q_needs_reset, q_dma_instr, q_math_instr, q_cache_instr,
    output dma_ready, math_ready, cache_ready
  );
endinterface

// File: rtl/iq_dispatcher.sv
// ---------------------------------------------------------------------------
// iq_dispatcher
//   Read-side engine of the superscalar instruction queue. Pops one row per
//   pop request, fans it out to the DMA, math and cache lanes, holds the next
//   row until every valid lane of the current row has been accepted, and runs
//   the position-exhaustion recovery (stop popping, drain, pulse q_reset).
//
// Ports
//   clk            : clock
//   reset          : asynchronous active-low reset
//   bus (master)   : queue read port, fe_hold, and the three lane handshakes
//   rows_issued_o  : retired-row counter, 16 bit, wrapping
//   stall_cycles_o : (DISPATCH_STALL_STATS_EN only) cycles a row is held
//                    without retiring, 32 bit, saturating
//   bubble_rows_o  : (DISPATCH_STALL_STATS_EN only) retired rows with no
//                    valid lane, 16 bit, wrapping
//
// Optional feature macro: DISPATCH_STALL_STATS_EN
// ---------------------------------------------------------------------------
module iq_dispatcher #(
  parameter int DMA_W        = 45,
  parameter int MATH_W       = 10,
  parameter int CACHE_W      = 46,
  parameter int RESET_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  iq_dispatcher_if.master      bus,
  output logic [15:0]          rows_issued_o
`ifdef DISPATCH_STALL_STATS_EN
  ,
  output logic [31:0]          stall_cycles_o,
  output logic [15:0]          bubble_rows_o
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RSTQ  = 2'd2;
  localparam logic [3:0] RST_LOAD = 4'(RESET_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pop_q;       // a pop was issued last cycle: row is on q_* now
  logic               pending_q, pending_d;
  logic [2:0]         done_q, done_d;
  logic [DMA_W-1:0]   dma_hold_q;
  logic [MATH_W-1:0]  math_hold_q;
  logic [CACHE_W-1:0] cache_hold_q;
  logic [15:0]        rows_q;

  logic               row_active;
  logic [DMA_W-1:0]   dma_word;
  logic [MATH_W-1:0]  math_word;
  logic [CACHE_W-1:0] cache_word;
  logic [2:0]         lane_v, lane_out_v, lane_rdy, lane_hs;
  logic               retire;
  logic               pop;

  // In the load cycle the row is taken straight from the queue outputs so a
  // fully-ready row retires in the same cycle it arrives (1 row/cycle).
  always_comb begin
    row_active = pop_q | pending_q;
    dma_word   = pop_q ? bus.q_dma_instr   : dma_hold_q;
    math_word  = pop_q ? bus.q_math_instr  : math_hold_q;
    cache_word = pop_q ? bus.q_cache_instr : cache_hold_q;
    lane_v     = {cache_word[CACHE_W-1], math_word[MATH_W-1], dma_word[DMA_W-1]}
                 & {3{row_active}};
    lane_out_v = lane_v & ~done_q;
    lane_rdy   = {bus.cache_ready, bus.math_ready, bus.dma_ready};
    lane_hs    = lane_out_v & lane_rdy;
    // A bubble row (no valid lane) satisfies this immediately.
    retire     = row_active & (&(~lane_v | done_q | lane_hs));
    pop        = (state_q == ST_RUN) && !bus.q_empty && !bus.q_needs_reset
                 && (!row_active || retire);
    pending_d  = row_active & ~retire;
    done_d     = retire ? 3'b000 : (done_q | lane_hs);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.q_needs_reset) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // row_active also covers a pop issued in the last RUN cycle.
        if (!row_active) begin
          state_d = ST_RSTQ;
          cnt_d   = RST_LOAD;
        end
      end
      ST_RSTQ: begin
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= 4'd0;
      pop_q        <= 1'b0;
      pending_q    <= 1'b0;
      done_q       <= 3'b000;
      dma_hold_q   <= '0;
      math_hold_q  <= '0;
      cache_hold_q <= '0;
      rows_q       <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pop_q     <= pop;
      pending_q <= pending_d;
      done_q    <= done_d;
      if (pop_q) begin
        dma_hold_q   <= bus.q_dma_instr;
        math_hold_q  <= bus.q_math_instr;
        cache_hold_q <= bus.q_cache_instr;
      end
      if (retire) rows_q <= rows_q + 16'd1;
    end
  end

`ifdef DISPATCH_STALL_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] bubble_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= 32'd0;
      bubble_q <= 16'd0;
    end else begin
      if (row_active && !retire && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (retire && (lane_v == 3'b000)) bubble_q <= bubble_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign bubble_rows_o  = bubble_q;
`endif

  assign bus.q_re        = pop;
  assign bus.q_reset     = (state_q == ST_RSTQ);
  assign bus.fe_hold     = (state_q != ST_RUN);
  assign bus.dma_valid   = lane_out_v[0];
  assign bus.math_valid  = lane_out_v[1];
  assign bus.cache_valid = lane_out_v[2];
  assign bus.dma_instr   = dma_word[DMA_W-2:0];
  assign bus.math_instr  = math_word[MATH_W-2:0];
  assign bus.cache_instr = cache_word[CACHE_W-2:0];
  assign rows_issued_o   = rows_q;

endmodule

// File: tb/tb_iq_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_iq_dispatcher
//   Queue model feeds rows on request and pushes the expected lane words into
//   per-lane scoreboards; a separate monitor pops and compares on every lane
//   handshake. Directed phases cover streaming, lane stall, bubbles, empty,
//   recovery and async reset; a random phase mixes valid bits, readies and
//   queue-empty gaps.
// ---------------------------------------------------------------------------
module tb_iq_dispatcher;
  localparam int DMA_W = 45, MATH_W = 10, CACHE_W = 46, RESET_CYCLES = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iq_dispatcher_if #(.DMA_W(DMA_W), .MATH_W(MATH_W), .CACHE_W(CACHE_W)) bus ();
  logic [15:0] rows_issued;
`ifdef DISPATCH_STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] bubble_rows;
`endif

  iq_dispatcher #(.DMA_W(DMA_W), .MATH_W(MATH_W), .CACHE_W(CACHE_W),
                  .RESET_CYCLES(RESET_CYCLES)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .rows_issued_o(rows_issued)
`ifdef DISPATCH_STALL_STATS_EN
    ,
    .stall_cycles_o(stall_cycles),
    .bubble_rows_o(bubble_rows)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- queue model ----------------
  logic [DMA_W-1:0]   mem_dma   [0:1023];
  logic [MATH_W-1:0]  mem_math  [0:1023];
  logic [CACHE_W-1:0] mem_cache [0:1023];
  int  pushed = 0;
  int  popped = 0;
  int  pops_since_rst = 0;
  logic force_empty = 1'b1;

  logic [DMA_W-2:0]   exp_dma[$];
  logic [MATH_W-2:0]  exp_math[$];
  logic [CACHE_W-2:0] exp_cache[$];

  assign bus.q_empty = force_empty || (pushed == popped);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      popped         <= pushed;
      pops_since_rst <= 0;
    end else if (bus.q_re) begin
      if (mem_dma[popped % 1024][DMA_W-1])     exp_dma.push_back(mem_dma[popped % 1024][DMA_W-2:0]);
      if (mem_math[popped % 1024][MATH_W-1])   exp_math.push_back(mem_math[popped % 1024][MATH_W-2:0]);
      if (mem_cache[popped % 1024][CACHE_W-1]) exp_cache.push_back(mem_cache[popped % 1024][CACHE_W-2:0]);
      bus.q_dma_instr   <= mem_dma[popped % 1024];
      bus.q_math_instr  <= mem_math[popped % 1024];
      bus.q_cache_instr <= mem_cache[popped % 1024];
      popped         <= popped + 1;
      pops_since_rst <= pops_since_rst + 1;
    end else begin
      // Outside a load cycle the queue outputs are junk the DUT must ignore.
      bus.q_dma_instr   <= DMA_W'(rnd64());
      bus.q_math_instr  <= MATH_W'(rnd64());
      bus.q_cache_instr <= CACHE_W'(rnd64());
    end
  end

  // ---------------- monitor ----------------
  logic              dma_stall = 1'b0, math_stall = 1'b0, cache_stall = 1'b0;
  logic [DMA_W-2:0]  dma_prev;
  logic [MATH_W-2:0] math_prev;
  logic [CACHE_W-2:0] cache_prev;

  always @(negedge clk) begin
    if (!reset) begin
      exp_dma.delete(); exp_math.delete(); exp_cache.delete();
      dma_stall <= 1'b0; math_stall <= 1'b0; cache_stall <= 1'b0;
    end else begin
      if (bus.dma_valid && bus.dma_ready) begin
        if (exp_dma.size() == 0) check("dma_unexpected", 64'(bus.dma_instr), 64'h0 - 64'h1);
        else check("dma_data", 64'(bus.dma_instr), 64'(exp_dma.pop_front()));
      end
      if (bus.math_valid && bus.math_ready) begin
        if (exp_math.size() == 0) check("math_unexpected", 64'(bus.math_instr), 64'h0 - 64'h1);
        else check("math_data", 64'(bus.math_instr), 64'(exp_math.pop_front()));
      end
      if (bus.cache_valid && bus.cache_ready) begin
        if (exp_cache.size() == 0) check("cache_unexpected", 64'(bus.cache_instr), 64'h0 - 64'h1);
        else check("cache_data", 64'(bus.cache_instr), 64'(exp_cache.pop_front()));
      end
      if (dma_stall)   check("dma_stable",   64'({bus.dma_valid, bus.dma_instr}),     64'({1'b1, dma_prev}));
      if (math_stall)  check("math_stable",  64'({bus.math_valid, bus.math_instr}),   64'({1'b1, math_prev}));
      if (cache_stall) check("cache_stable", 64'({bus.cache_valid, bus.cache_instr}), 64'({1'b1, cache_prev}));
      dma_stall   <= bus.dma_valid && !bus.dma_ready;
      math_stall  <= bus.math_valid && !bus.math_ready;
      cache_stall <= bus.cache_valid && !bus.cache_ready;
      dma_prev    <= bus.dma_instr;
      math_prev   <= bus.math_instr;
      cache_prev  <= bus.cache_instr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input bit dv, input bit mv, input bit cv);
    logic [63:0] r;
    r = rnd64(); mem_dma[pushed % 1024]   = {dv, r[DMA_W-2:0]};
    r = rnd64(); mem_math[pushed % 1024]  = {mv, r[MATH_W-2:0]};
    r = rnd64(); mem_cache[pushed % 1024] = {cv, r[CACHE_W-2:0]};
    pushed++;
  endtask

  task automatic set_ready(input bit d, input bit m, input bit c);
    bus.dma_ready = d; bus.math_ready = m; bus.cache_ready = c;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (pushed == popped && exp_dma.size() == 0 && exp_math.size() == 0 &&
          exp_cache.size() == 0 && !bus.dma_valid && !bus.math_valid &&
          !bus.cache_valid && !bus.q_re) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
    cyc();
  endtask

  initial begin
    int nq, nd, nm, nc, nv, nrst;
    logic [15:0] base;
    bit seen_rst, done_rst;

    bus.q_needs_reset = 1'b0;
    set_ready(0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_q_re", 64'(bus.q_re), 0);
    check("rst_valids", 64'({bus.dma_valid, bus.math_valid, bus.cache_valid}), 0);
    check("rst_instr", 64'(bus.dma_instr), 0);
    check("rst_rows", 64'(rows_issued), 0);
    check("rst_qreset_hold", 64'({bus.q_reset, bus.fe_hold}), 0);
    cyc();
    reset = 1'b1;

    // Empty then stream: 4 full rows, all ready
    cyc();
    set_ready(1, 1, 1);
    for (int i = 0; i < 4; i++) push_row(1, 1, 1);
    @(negedge clk);
    check("empty_q_re", 64'(bus.q_re), 0);
    check("empty_valid", 64'({bus.dma_valid, bus.math_valid, bus.cache_valid}), 0);
    cyc();
    force_empty = 1'b0;
    @(negedge clk);
    check("empty_fall_q_re", 64'(bus.q_re), 1);
    check("empty_fall_valid", 64'(bus.dma_valid), 0);
    nq = 1; nd = 0; nm = 0; nc = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      @(negedge clk);
      if (i == 0) check("stream_first_valid", 64'({bus.dma_valid, bus.math_valid, bus.cache_valid}), 64'h7);
      nq += int'(bus.q_re); nd += int'(bus.dma_valid);
      nm += int'(bus.math_valid); nc += int'(bus.cache_valid);
    end
    check("stream_q_re_cycles", 64'(nq), 4);
    check("stream_dma_cycles", 64'(nd), 4);
    check("stream_math_cycles", 64'(nm), 4);
    check("stream_cache_cycles", 64'(nc), 4);
    check("stream_rows", 64'(rows_issued), 4);

    // Lane stall: math not ready for 3 cycles
    cyc();
    force_empty = 1'b1;
    set_ready(1, 0, 1);
    push_row(1, 1, 1);
    push_row(1, 1, 1);
    cyc();
    force_empty = 1'b0;
    @(negedge clk);
    check("stall_pop0", 64'(bus.q_re), 1);
    cyc(); @(negedge clk);
    check("stall_c1_valid", 64'({bus.dma_valid, bus.math_valid, bus.cache_valid}), 64'h7);
    check("stall_c1_q_re", 64'(bus.q_re), 0);
    for (int i = 2; i <= 3; i++) begin
      cyc(); @(negedge clk);
      check("stall_wait_valid", 64'({bus.dma_valid, bus.math_valid, bus.cache_valid}), 64'h2);
      check("stall_wait_q_re", 64'(bus.q_re), 0);
    end
    cyc();
    bus.math_ready = 1'b1;
    @(negedge clk);
    check("stall_c4_math", 64'(bus.math_valid), 1);
    check("stall_c4_q_re", 64'(bus.q_re), 1);
    cyc(); @(negedge clk);
    check("stall_c5_row1", 64'(bus.dma_valid), 1);
    wait_idle("stall_idle");
    check("stall_rows", 64'(rows_issued), 6);

    // Bubble between two full rows
    force_empty = 1'b1;
    push_row(1, 1, 1);
    push_row(0, 0, 0);
    push_row(1, 1, 1);
    base = rows_issued;
    cyc();
    force_empty = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nv += int'(bus.dma_valid || bus.math_valid || bus.cache_valid);
      cyc();
    end
    check("bubble_valid_slots", 64'(nv), 2);
    check("bubble_rows_delta", 64'(rows_issued - base), 3);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      cyc();
      set_ready($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
      if (c < 350 && $urandom_range(0, 1) == 1)
        push_row(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cyc();
    set_ready(1, 1, 1);
    force_empty = 1'b0;
    wait_idle("random_idle");
    check("random_rows", 64'(rows_issued), 64'(pops_since_rst[15:0]));

    // Recovery while a row waits on cache_ready
    set_ready(1, 1, 0);
    force_empty = 1'b1;
    push_row(1, 1, 1);
    push_row(1, 1, 1);
    push_row(1, 0, 1);
    cyc();
    force_empty = 1'b0;            // c0: pop row
    cyc();                         // c1: load, cache stalls
    cyc();                         // c2: exhaustion flagged
    bus.q_needs_reset = 1'b1;
    @(negedge clk);
    check("rec_c2_fe_hold", 64'(bus.fe_hold), 0);
    check("rec_c2_q_re", 64'(bus.q_re), 0);
    cyc(); @(negedge clk);
    check("rec_drain_hold", 64'({bus.fe_hold, bus.q_reset, bus.q_re}), 64'h4);
    check("rec_drain_cache", 64'(bus.cache_valid), 1);
    cyc();
    bus.cache_ready = 1'b1;
    nrst = 0; seen_rst = 1'b0; done_rst = 1'b0;
    for (int i = 0; i < 20 && !done_rst; i++) begin
      @(negedge clk);
      if (bus.q_reset) begin
        nrst++;
        seen_rst = 1'b1;
        check("rec_rst_fe_hold", 64'(bus.fe_hold), 1);
      end else if (seen_rst) begin
        done_rst = 1'b1;
        check("rec_run_fe_hold", 64'(bus.fe_hold), 0);
        check("rec_run_q_re", 64'(bus.q_re), 1);
      end else begin
        check("rec_drain_q_re", 64'(bus.q_re), 0);
      end
      cyc();
      if (seen_rst) bus.q_needs_reset = 1'b0;
    end
    check("rec_finished", 64'(done_rst), 1);
    check("rec_q_reset_cycles", 64'(nrst), 64'(RESET_CYCLES));
    wait_idle("rec_idle");
    check("rec_rows", 64'(rows_issued), 64'(pops_since_rst[15:0]));

    // Async reset mid-stall
    set_ready(1, 1, 0);
    force_empty = 1'b1;
    push_row(1, 1, 1);
    cyc();
    force_empty = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    check("arst_pre_cache", 64'(bus.cache_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valids", 64'({bus.dma_valid, bus.math_valid, bus.cache_valid}), 0);
    check("arst_rows", 64'(rows_issued), 0);
    check("arst_ctrl", 64'({bus.q_re, bus.q_reset, bus.fe_hold}), 0);
    cyc(); cyc();
    reset = 1'b1;
    set_ready(1, 1, 1);
    push_row(1, 1, 1);
    @(negedge clk);
    check("arst_run_q_re", 64'(bus.q_re), 1);
    wait_idle("arst_idle");
    check("arst_rows_after", 64'(rows_issued), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iq_dispatcher.md
Name: iq_dispatcher

Overview:
- Read-side engine for the superscalar instruction queue; drains it one virtual-array row (timeslot) per pop.
- Per pop, fans the row out to three execution lanes: DMA, math and cache/regfile. Each lane has its own valid/ready handshake.
- Keeps lane ordering by holding back the next row until every valid lane of the current row has been accepted.
- Owns the queue's position-exhaustion recovery: stops popping, drains in-flight work, then pulses the queue reset.

Parameters:
DMA_W, 45, width of DMA instruction word incl. valid bit at MSB
MATH_W, 10, width of math instruction word incl. valid bit at MSB
CACHE_W, 46, width of cache instruction word incl. valid bit at MSB
RESET_CYCLES, 2, cycles q_reset is held high during recovery (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
q_re  out  1  pop request to queue; row data valid on q_* exactly 1 cycle later
q_empty  in  1  queue has no readable row
q_needs_reset  in  1  queue read position exhausted
q_reset  out  1  reset pulse to queue
q_dma_instr  in  DMA_W  popped DMA word
q_math_instr  in  MATH_W  popped math word
q_cache_instr  in  CACHE_W  popped cache word
fe_hold  out  1  front end must not push while high
dma_valid / dma_ready / dma_instr  out/in/out  1/1/DMA_W-1  DMA lane handshake (valid bit stripped)
math_valid / math_ready / math_instr  out/in/out  1/1/MATH_W-1  math lane
cache_valid / cache_ready / cache_instr  out/in/out  1/1/CACHE_W-1  cache lane
rows_issued  out  16  count of retired rows, wraps at 65535->0

Behaviour:
- Reset (async assert, sync deassert):
  - state=RUN; q_re=0, q_reset=0, fe_hold=0.
  - All *_valid=0; all *_instr=0; rows_issued=0.
  - pending flag clear; per-lane done flags clear.
- Row holding register: one per lane.
  - Loaded in the cycle after q_re (pending=1), from the q_* words.
  - Lane valid = MSB of its word. *_valid = lane valid AND NOT lane done.
  - A lane handshake (valid&&ready) sets that lane's done flag.
- Row retire: the row retires when every valid lane is done or handshakes this cycle.
  - On retire: clear done flags, increment rows_issued.
  - A row with no valid lanes (bubble) retires in its load cycle; the slot is still consumed.
- Pop rule:
  - q_re = (state==RUN) && !q_empty && !q_needs_reset && (!pending || retire_this_cycle).
  - At most one outstanding pop. Back-to-back rows sustain 1 row/cycle when all lanes are ready.
- State machine:
  - RUN: if q_needs_reset is high, go to DRAIN next cycle. A pop issued that same cycle still completes normally.
  - DRAIN: q_re=0, fe_hold=1. When pending==0 and no pop is outstanding, go to RSTQ.
  - RSTQ: q_reset=1 and fe_hold=1 for exactly RESET_CYCLES cycles (4-bit down-counter), then return to RUN. In that first RUN cycle q_reset=0 and fe_hold=0.
- Boundary rules:
  - q_empty and q_needs_reset high together: DRAIN wins.
  - ready may toggle while valid is high; valid and instr stay stable until the handshake.
  - Async reset mid-row discards the held row. Nothing is replayed; the queue is reset by the same global reset.
  - q_* inputs are ignored in any cycle not directly following q_re.

Optional Feature:
Macro DISPATCH_STALL_STATS_EN.
- Defined: adds output stall_cycles (32 bits, saturating, reset 0). It increments every cycle pending==1 and the row does not retire.
- Defined: adds output bubble_rows (16 bits, wrapping, reset 0). It increments on every retired row with no valid lanes.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Test Plan:
- Stream: queue holds 4 rows with all lanes valid; all readies held at 1 -> q_re high 4 consecutive cycles; each lane valid 4 cycles; rows_issued=4.
- Lane stall: row0 has all lanes valid; math_ready=0 for 3 cycles, others 1 -> dma and cache handshake in cycle 1, math in cycle 4; q_re for row1 only in the cycle math handshakes; dma_valid stays 0 meanwhile.
- Bubble: row of all-invalid words between two full rows -> no lane valid for that slot; rows_issued advances by 3 over the 3 rows.
- Empty: q_empty=1 -> q_re stays 0 and all valids 0; q_empty falls -> q_re in that cycle, lane valids one cycle later.
- Recovery: q_needs_reset rises while a row waits on cache_ready=0 -> fe_hold=1 next cycle; q_re stays 0; after the cache handshake q_reset is high for exactly 2 cycles (RESET_CYCLES=2), then fe_hold=0 and q_re resumes.
- Async reset: assert reset low mid-stall -> all valids 0 immediately, rows_issued=0, state RUN after release.
